// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   state_e      : arbiter FSM states
//   DEF_*        : default parameter values
//   GRANT_W      : grant index width for the default requester count
//   wrap_inc     : modulo-n increment helper
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_ACK_WAIT = 4;
  localparam int unsigned GRANT_W      = $clog2(DEF_NUM_REQ);

  // (idx + 1) mod n, used to start the round-robin search after the last grant
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Round-robin picker: finds the first set request starting one past ptr.
//   req     : request vector
//   ptr     : index of the last granted requester
//   gnt_oh  : one-hot grant (zero when nothing requested)
//   gnt_idx : index of the granted requester
//   any     : at least one request is set
module rr_picker
  import synth_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = GRANT_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  // Scan NUM_REQ positions beginning after ptr; first hit wins
  always_comb begin
    int unsigned idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = wrap_inc(32'(ptr) + i, NUM_REQ);
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt_idx     = IDX_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// One byte per grant; drives the transmitter start/ready handshake and
// re-issues start if the transmitter does not go busy within ACK_WAIT cycles.
//   req_valid/req_data/req_ready : producer side, byte taken on valid & ready
//   uart_ready/uart_start/uart_data : transmitter side
//   grant_id : last granted requester, busy : FSM not in IDLE
module uart_tx_arbiter
  import synth_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned ACK_WAIT = DEF_ACK_WAIT,
  localparam int unsigned GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      uart_ready,
  output logic                      uart_start,
  output logic [DATA_W-1:0]         uart_data,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(ACK_WAIT + 1);

  state_e              state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  gnt_oh;
  logic [GW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [DATA_W-1:0]   sel_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Byte of the current winner
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Capture strobe only while IDLE with an idle transmitter
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && uart_ready) req_ready = gnt_oh;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (uart_ready && gnt_any) begin
          data_d  = sel_data;
          grant_d = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A high ready here means the start was not accepted yet
        if (!uart_ready) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(ACK_WAIT)) state_d = START;
        end
      end
      WAIT_DONE: begin
        if (uart_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
  end

  // State register; pointer resets to the last index so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_start = start_q;
  assign uart_data  = data_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int FRAME = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        uart_ready = 1'b1;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic [1:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .ACK_WAIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .uart_ready (uart_ready),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Start log and transmitter model, evaluated on the falling edge
  logic [7:0] log_data[$];
  int         log_gid[$];
  int         log_cyc[$];
  int         log_gap[$];
  int         cyc = 0;
  int         last_rise = 0;
  int         dbl_cnt = 0;
  bit         prev_start = 1'b0;
  bit         hold_low = 1'b0;
  int         ignore_starts = 0;
  int         low_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (uart_start) begin
      log_data.push_back(uart_data);
      log_gid.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
      log_gap.push_back(cyc - last_rise);
      if (prev_start) dbl_cnt++;
    end
    prev_start = uart_start;
    if (hold_low) begin
      uart_ready = 1'b0;
      low_cnt    = 0;
    end else if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) begin
        uart_ready = 1'b1;
        last_rise  = cyc;
      end
    end else begin
      uart_ready = 1'b1;
      if (uart_start) begin
        if (ignore_starts > 0) ignore_starts--;
        else begin
          uart_ready = 1'b0;
          low_cnt    = FRAME;
        end
      end
    end
  end

  task automatic clear_log();
    log_data.delete(); log_gid.delete(); log_cyc.delete(); log_gap.delete();
    dbl_cnt = 0;
  endtask

  task automatic do_reset();
    hold_low  = 1'b1;
    req_valid = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    hold_low = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || !uart_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (busy || !uart_ready) begin
      errors++; $display("FAIL %s idle timeout busy=%0b ready=%0b", name, busy, uart_ready);
    end
  endtask

  task automatic wait_starts(input int want, input string name);
    int n = 0;
    while (log_data.size() < want && n < 400) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (log_data.size() < want) begin
      errors++; $display("FAIL %s start timeout got=%0d need=%0d", name, log_data.size(), want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (uart_start !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", uart_start); end
    checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", uart_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
  endtask

  task automatic test_single();
    bit saw_low = 1'b0;
    int n = 0;
    do_reset();
    @(negedge clk);
    req_data  = 32'h0000_00A5;
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    @(negedge clk); #1;
    checks++; if (uart_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", uart_start); end
    checks++; if (uart_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", uart_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
    req_valid = '0;
    while (busy && n < 100) begin
      if (!uart_ready) saw_low = 1'b1;
      @(negedge clk); #1; n++;
    end
    checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL single_busy_span saw_low=%b exp=1", saw_low); end
    checks++; if (busy !== 1'b0 || uart_ready !== 1'b1) begin errors++; $display("FAIL single_end busy=%b ready=%b exp 0/1", busy, uart_ready); end
    checks++; if (log_data.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", log_data.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    wait_starts(5, "rr");
    req_valid = '0;
    wait_idle("rr");
    for (int k = 0; k < 5 && k < log_data.size(); k++) begin
      checks++;
      if (log_data[k] !== 8'(8'h10 + k % 4) || log_gid[k] != k % 4) begin
        errors++; $display("FAIL rr_order[%0d] got data=%h gid=%0d exp data=%h gid=%0d",
                           k, log_data[k], log_gid[k], 8'(8'h10 + k % 4), k % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data  = 32'h005C_0000;
    req_valid = 4'b0100;
    wait_starts(5, "b2b");
    req_valid = '0;
    wait_idle("b2b");
    checks++; if (log_data.size() != 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", log_data.size()); end
    checks++; if (dbl_cnt != 0) begin errors++; $display("FAIL b2b_pulse_width wide_pulses=%0d exp=0", dbl_cnt); end
    for (int k = 0; k < 5 && k < log_data.size(); k++) begin
      checks++;
      if (log_data[k] !== 8'h5C || log_gid[k] != 2) begin
        errors++; $display("FAIL b2b_byte[%0d] got data=%h gid=%0d exp 5c/2", k, log_data[k], log_gid[k]);
      end
      if (k > 0) begin
        checks++;
        if (log_gap[k] != 2) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d exp=2", k, log_gap[k]); end
      end
    end
  endtask

  task automatic test_retry();
    do_reset();
    ignore_starts = 1;
    @(negedge clk);
    req_data  = 32'h0000_3C00;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL retry_ready got=%b exp=0010", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      checks++;
      if (uart_start !== ((k == 1 || k == 6) ? 1'b1 : 1'b0) || req_ready !== 4'b0000 || uart_data !== 8'h3C) begin
        errors++; $display("FAIL retry_cycle[%0d] start=%b req_ready=%b data=%h exp start=%b req_ready=0000 data=3c",
                           k, uart_start, req_ready, uart_data, (k == 1 || k == 6));
      end
    end
    req_valid = '0;
    wait_idle("retry");
    checks++; if (log_data.size() != 2) begin errors++; $display("FAIL retry_count got=%0d exp=2", log_data.size()); end
    if (log_data.size() >= 2) begin
      checks++;
      if (log_cyc[1] - log_cyc[0] != 5 || log_data[1] !== 8'h3C) begin
        errors++; $display("FAIL retry_repulse spacing=%0d data=%h exp 5/3c", log_cyc[1] - log_cyc[0], log_data[1]);
      end
    end
  endtask

  task automatic test_ready_low();
    int n = 0;
    hold_low  = 1'b1;
    rst_n     = 1'b0;
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0000 || uart_start !== 1'b0) begin
        errors++; $display("FAIL lowrdy_block[%0d] req_ready=%b start=%b exp 0000/0", k, req_ready, uart_start);
      end
    end
    hold_low = 1'b0;
    while (!uart_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lowrdy_first got=%b exp=0001", req_ready); end
    @(negedge clk); #1;
    checks++;
    if (uart_start !== 1'b1 || grant_id !== 2'd0 || uart_data !== 8'h10) begin
      errors++; $display("FAIL lowrdy_grant start=%b gid=%0d data=%h exp 1/0/10", uart_start, grant_id, uart_data);
    end
    req_valid = '0;
    wait_idle("lowrdy");
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    while (uart_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_start !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || uart_data !== 8'h00 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_outputs start=%b busy=%b gid=%0d data=%h req_ready=%b exp all zero",
                         uart_start, busy, grant_id, uart_data, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    req_valid = 4'b1111;
    wait_starts(1, "midrst");
    req_valid = '0;
    if (log_data.size() >= 1) begin
      checks++;
      if (log_gid[0] != 0 || log_data[0] !== 8'h10) begin
        errors++; $display("FAIL midrst_next gid=%0d data=%h exp 0/10", log_gid[0], log_data[0]);
      end
    end
    wait_idle("midrst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_retry();
    test_ready_low();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (`uart_tx_out_mod`: start/data in, ready out) between up to NUM_REQ byte producers, e.g. sample stream, note-on/off events and status bytes.
- Round-robin grant, one byte per grant; sequences the start/ready handshake of the transmitter.
- Replaces the current free-running "start whenever ready" logic in top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- ACK_WAIT, 4, cycles to wait for uart_ready to fall after a start pulse before re-issuing start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte.
- req_data  in  NUM_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot capture strobe; byte i is taken when req_valid[i] & req_ready[i].
- uart_ready  in  1  transmitter idle (high) / busy (low).
- uart_start  out  1  one-cycle start pulse to the transmitter.
- uart_data  out  DATA_W  byte presented to the transmitter; held stable from capture until return to IDLE.
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release) values:
  - uart_start=0, uart_data=0, grant_id=0, busy=0.
  - req_ready=0, state=IDLE.
  - Round-robin pointer set so requester 0 has top priority.
- req_ready is combinational: asserted only in IDLE, with uart_ready=1, for the winner among valid requesters. All other outputs are registered.
- Arbitration order: search starts at (last grant + 1) mod NUM_REQ; the pointer advances only on a capture.
- IDLE:
  - If uart_ready=1 and any req_valid: capture the winner's byte into uart_data, set grant_id, go to START.
  - Otherwise stay in IDLE.
- START: uart_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - uart_ready=0 -> go to WAIT_DONE.
  - Else increment the counter; when it reaches ACK_WAIT -> return to START and re-pulse with the same byte (no new capture).
- WAIT_DONE: uart_ready=1 -> go to IDLE.
- Latency: valid in IDLE at cycle N -> req_ready high in cycle N -> uart_start high in cycle N+1.
- Back-to-back throughput: one byte per UART frame plus 2 cycles.
- Boundary conditions:
  - A requester may drop valid before capture without penalty; nothing is latched for it.
  - uart_ready low in IDLE: no grant, all req_ready low.
  - All requesters valid continuously: grants cycle 0,1,2,3,0 with no starvation.
  - uart_ready bouncing high during WAIT_ACK before any low: counted as not accepted.
  - Reset mid-frame: the in-flight byte is discarded and the start pulse is cut immediately.
  - Captured data is never overwritten until IDLE is re-entered.

Decomposition:
- Shared package `synth_pkg`:
  - state enum: IDLE, START, WAIT_ACK, WAIT_DONE.
  - width constant GRANT_W = clog2(NUM_REQ).
  - localparam for the default ACK_WAIT.
- One natural combinational sub-module, `rr_picker`:
  - inputs: NUM_REQ request vector and pointer.
  - outputs: one-hot grant, grant index, any flag.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5, model transmitter idle -> req_ready=0001 same cycle; uart_start one cycle later with uart_data=A5; busy=1 until uart_ready returns high.
- All four valid constantly, data 8'h10..8'h13 -> transmitted order 10,11,12,13,10; grant_id 0,1,2,3,0.
- Requester 2 only, valid held 5 frames -> 5 bytes sent; uart_start pulses exactly once per frame; 2-cycle gap between ready rise and next start.
- Transmitter model ignores the first start (ready stays high) -> start re-pulsed after ACK_WAIT=4 cycles with the same uart_data; req_ready not re-asserted.
- uart_ready held low at reset release with req_valid=1111 -> no req_ready, no start; release ready -> requester 0 granted first.
- Assert rst_n=0 during WAIT_DONE -> outputs return to reset values immediately; after release the next grant starts at requester 0.
